// File: rtl/life_step_engine.sv
// life_step_engine
//   Sequential Game-of-Life generation engine for an N x N LED matrix.
//   The live board is loaded row by row from the switch-entry logic. Each
//   step request computes the next generation one row per clock into a shadow
//   buffer. The whole board is then committed in a single cycle, so o_board
//   never shows a partially computed generation.
//
// Ports
//   i_clk        system clock, all state on posedge
//   i_rst        asynchronous active-high reset
//   i_load_en    write i_load_data into board row i_load_row (IDLE only)
//   i_load_row   target row for a load
//   i_load_data  row contents, bit c = column c (1 = alive)
//   i_step       request one generation (IDLE only; a load in the same cycle wins)
//   o_busy       high while computing or committing
//   o_done       one-cycle pulse, high while o_board shows the new generation
//   o_gen_count  generations committed since reset or the last load
//   o_pop_count  live cells as of the last commit
//   o_board      registered board, o_board[r][c]
module life_step_engine #(
    parameter int N    = 16,
    parameter bit WRAP = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load_en,
    input  logic [$clog2(N)-1:0]         i_load_row,
    input  logic [N-1:0]                 i_load_data,
    input  logic                         i_step,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [15:0]                  o_gen_count,
    output logic [$clog2(N*N+1)-1:0]     o_pop_count,
    output logic [N-1:0][N-1:0]          o_board
);
    localparam int RW = $clog2(N);
    localparam int PW = $clog2(N*N+1);
    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [RW-1:0]         r_ptr;
    logic [N-1:0][N-1:0]   r_board;
    logic [N-1:0][N-1:0]   r_shadow;
    logic [15:0]           r_gen;
    logic [PW-1:0]         r_pop;
    logic [PW-1:0]         r_acc;
    logic                  r_done;

    logic                  w_ptr_last;
    logic [N-1:0]          w_up, w_mid, w_dn, w_next;
    logic [CW-1:0]         w_row_pop;

    assign w_ptr_last = (r_ptr == RW'(N-1));

    // Neighbour rows of the row being computed; off-board rows read as dead
    // when the torus is disabled.
    always_comb begin
        w_mid = r_board[r_ptr];
        if (r_ptr == '0)
            w_up = WRAP ? r_board[N-1] : '0;
        else
            w_up = r_board[r_ptr - RW'(1)];
        if (w_ptr_last)
            w_dn = WRAP ? r_board[0] : '0;
        else
            w_dn = r_board[r_ptr + RW'(1)];
    end

    // Per-column neighbour count and cell rule. Column neighbours are fixed
    // per column, so the wrap/edge decision is resolved at elaboration.
    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int CL = (c == 0)   ? N-1 : c-1;
        localparam int CR = (c == N-1) ? 0   : c+1;
        localparam bit EL = WRAP || (c != 0);
        localparam bit ER = WRAP || (c != N-1);
        logic [3:0] w_cnt;
        assign w_cnt = 4'(w_up[c]) + 4'(w_dn[c])
                     + (EL ? 4'(w_up[CL]) + 4'(w_mid[CL]) + 4'(w_dn[CL]) : 4'd0)
                     + (ER ? 4'(w_up[CR]) + 4'(w_mid[CR]) + 4'(w_dn[CR]) : 4'd0);
        assign w_next[c] = w_mid[c] ? (w_cnt == 4'd2 || w_cnt == 4'd3)
                                    : (w_cnt == 4'd3);
    end

    always_comb begin
        w_row_pop = '0;
        for (int c = 0; c < N; c++)
            w_row_pop = w_row_pop + CW'(w_next[c]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!i_load_en && i_step) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_ptr_last)           w_state_nxt = S_COMMIT;
            S_COMMIT:                            w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr    <= '0;
            r_board  <= '0;
            r_shadow <= '0;
            r_gen    <= '0;
            r_pop    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            case (r_state)
                S_IDLE: begin
                    if (i_load_en) begin
                        if (32'(i_load_row) < N)
                            r_board[i_load_row] <= i_load_data;
                        r_gen <= '0;
                    end else if (i_step) begin
                        r_ptr <= '0;
                        r_acc <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_shadow[r_ptr] <= w_next;
                    r_acc           <= r_acc + PW'(w_row_pop);
                    r_ptr           <= w_ptr_last ? '0 : r_ptr + RW'(1);
                end
                S_COMMIT: begin
                    r_board <= r_shadow;
                    r_pop   <= r_acc;
                    r_gen   <= r_gen + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_gen_count = r_gen;
    assign o_pop_count = r_pop;
    assign o_board     = r_board;
endmodule

// File: tb/tb_life_step_engine.sv
module tb_life_step_engine;
    localparam int N = 16;

    typedef logic [N-1:0][N-1:0] board_t;
    typedef struct {
        board_t      board;
        logic [15:0] gen;
        logic [8:0]  pop;
        bit          chk_board;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_en = 1'b0, step = 1'b0;
    logic [3:0] ld_row = '0;
    logic [N-1:0] ld_data = '0;
    bit use1 = 1'b1, use0 = 1'b0;

    logic busy1, done1, busy0, done0;
    logic [15:0] gen1, gen0;
    logic [8:0] pop1, pop0;
    board_t brd1, brd0;

    int checks = 0, errors = 0, cyc = 0;
    exp_t q1[$], q0[$];
    logic prev1 = 1'b0, prev0 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    life_step_engine #(.N(N), .WRAP(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_en(ld_en & use1), .i_load_row(ld_row),
        .i_load_data(ld_data), .i_step(step & use1), .o_busy(busy1), .o_done(done1),
        .o_gen_count(gen1), .o_pop_count(pop1), .o_board(brd1));

    life_step_engine #(.N(N), .WRAP(1'b0)) dut_nowrap (
        .i_clk(clk), .i_rst(rst), .i_load_en(ld_en & use0), .i_load_row(ld_row),
        .i_load_data(ld_data), .i_step(step & use0), .o_busy(busy0), .o_done(done0),
        .o_gen_count(gen0), .o_pop_count(pop0), .o_board(brd0));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input string tag, input exp_t e, input board_t b, input logic [15:0] g,
                       input logic [8:0] p);
        chk({tag, " done cycle"}, 256'(cyc), 256'(e.cyc));
        chk({tag, " gen_count"}, 256'(g), 256'(e.gen));
        chk({tag, " pop_count"}, 256'(p), 256'(e.pop));
        if (e.chk_board) chk({tag, " board"}, b, e.board);
    endtask

    // Monitors: every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && done1) begin
            chk("wrap done width", 256'(prev1), 256'(0));
            if (q1.size() == 0) chk("wrap unexpected done", 256'(1), 256'(0));
            else mon("wrap", q1.pop_front(), brd1, gen1, pop1);
        end
        prev1 = done1;
    end

    always @(negedge clk) begin
        if (!rst && done0) begin
            chk("nowrap done width", 256'(prev0), 256'(0));
            if (q0.size() == 0) chk("nowrap unexpected done", 256'(1), 256'(0));
            else mon("nowrap", q0.pop_front(), brd0, gen0, pop0);
        end
        prev0 = done0;
    end

    task automatic load(input int r, input logic [N-1:0] d);
        ld_en = 1'b1; ld_row = 4'(r); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load_board(input board_t b);
        for (int r = 0; r < N; r++) load(r, b[r]);
    endtask

    // Issue a step at a negedge; step is sampled at the next posedge (edge 0),
    // so the done pulse is visible at the negedge after edge 17.
    task automatic issue(input bit to1, input exp_t e1, input bit to0, input exp_t e0);
        exp_t t1, t0;
        t1 = e1; t0 = e0;
        t1.cyc = cyc + 18; t0.cyc = cyc + 18;
        if (to1) q1.push_back(t1);
        if (to0) q0.push_back(t0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (q1.size() != 0 || q0.size() != 0); i++) @(negedge clk);
        if (q1.size() != 0 || q0.size() != 0) begin
            chk("done timeout", 256'(q1.size() + q0.size()), 256'(0));
            q1.delete(); q0.delete();
        end
        @(negedge clk);
    endtask

    function automatic exp_t mk(input board_t b, input int g, input int p, input bit cb);
        exp_t e;
        e.board = b; e.gen = 16'(g); e.pop = 9'(p); e.chk_board = cb; e.cyc = 0;
        return e;
    endfunction

    initial begin
        board_t seed, vert, glider, glider4, corner, zero;
        exp_t none;
        zero = '0;
        none = mk(zero, 0, 0, 1'b0);
        seed = '0; seed[7] = 16'h0380;
        vert = '0; vert[6] = 16'h0100; vert[7] = 16'h0100; vert[8] = 16'h0100;
        glider = '0; glider[0] = 16'h0002; glider[1] = 16'h0004; glider[2] = 16'h0007;
        glider4 = '0; glider4[1] = 16'h0004; glider4[2] = 16'h0008; glider4[3] = 16'h000E;
        corner = '0; corner[0] = 16'h8001; corner[15] = 16'h8001;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset board", brd1, zero);
        chk("reset busy", 256'(busy1), 256'(0));
        chk("reset done", 256'(done1), 256'(0));
        chk("reset gen", 256'(gen1), 256'(0));
        chk("reset pop", 256'(pop1), 256'(0));

        // Blinker, with busy and a frozen board through the compute window
        load_board(seed);
        issue(1'b1, mk(vert, 1, 3, 1'b1), 1'b0, none);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("blinker busy", 256'(busy1), 256'(1));
            chk("blinker board frozen", brd1, seed);
        end
        wait_drain();
        chk("blinker busy after", 256'(busy1), 256'(0));
        issue(1'b1, mk(seed, 2, 3, 1'b1), 1'b0, none);
        wait_drain();

        // Glider on the torus: shifted by (1,1) after 4, home after 64
        load_board(glider);
        for (int g = 1; g <= 64; g++) begin
            issue(1'b1, mk(g == 4 ? glider4 : glider, g, 5, g == 4 || g == 64), 1'b0, none);
            wait_drain();
        end

        // Corner block on both neighbourhood modes
        use0 = 1'b1;
        load_board(corner);
        issue(1'b1, mk(corner, 1, 4, 1'b1), 1'b1, mk(zero, 1, 0, 1'b1));
        wait_drain();
        use0 = 1'b0;

        // Handshake: requests while busy are ignored
        load_board(seed);
        issue(1'b1, mk(vert, 1, 3, 1'b1), 1'b0, none);
        repeat (4) @(negedge clk);
        step = 1'b1; ld_en = 1'b1; ld_row = 4'd3; ld_data = 16'hFFFF;
        @(negedge clk);
        step = 1'b0; ld_en = 1'b0;
        wait_drain();
        chk("busy-ignored row3", 256'(brd1[3]), 256'(0));
        // In IDLE, load beats step
        step = 1'b1; ld_en = 1'b1; ld_row = 4'd3; ld_data = 16'hFFFF;
        @(negedge clk);
        step = 1'b0; ld_en = 1'b0;
        chk("load+step row3", 256'(brd1[3]), 256'(16'hFFFF));
        chk("load+step gen", 256'(gen1), 256'(0));
        repeat (3) @(negedge clk);
        chk("load+step busy", 256'(busy1), 256'(0));
        repeat (20) @(negedge clk);

        // Reset in the middle of COMPUTE: no done pulse ever follows
        load_board(seed);
        step = 1'b1;
        @(posedge clk);
        step = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midreset board", brd1, zero);
        chk("midreset busy", 256'(busy1), 256'(0));
        chk("midreset gen", 256'(gen1), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midreset board after", brd1, zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
